// File: rtl/gerador_verificador.sv
// Exhaustive test-vector generator and checker for an external WIDTH-bit equality comparator.
// Sweeps every {a,b} pair once per start, counts mismatches and records the first failing vector.
module gerador_verificador #(
  parameter int WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 y_in,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic [2*WIDTH-1:0]   first_fail,
  output logic [1:0]           o_dbg_state
);

  localparam int VW = 2 * WIDTH;
  localparam logic [VW-1:0] LAST_VEC = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [VW-1:0]   r_vec;
  logic [VW:0]     r_err;
  logic [VW-1:0]   r_first;
  logic            r_seen;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic            w_expected;
  logic            w_mismatch;
  logic [VW:0]     w_err_next;
  logic            w_enter_run;

  // start is only honoured outside RUN, so a sweep can never be restarted or stretched.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_vec == LAST_VEC) w_next = DONE;
      DONE:    if (start) w_next = RUN;
      default: w_next = IDLE;
    endcase
  end

  assign w_expected  = (r_vec[VW-1:WIDTH] == r_vec[WIDTH-1:0]);
  assign w_mismatch  = (r_state == RUN) && (y_in != w_expected);
  assign w_err_next  = r_err + {{VW{1'b0}}, w_mismatch};
  assign w_enter_run = (r_state != RUN) && (w_next == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_vec   <= '0;
      r_err   <= '0;
      r_first <= '0;
      r_seen  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == RUN);
      r_done  <= (w_next == DONE);
      // In DONE no mismatch is counted, so w_err_next equals the held count.
      r_pass  <= (w_next == DONE) && (w_err_next == '0);
      if (w_enter_run) begin
        r_vec   <= '0;
        r_err   <= '0;
        r_first <= '0;
        r_seen  <= 1'b0;
      end else if (r_state == RUN) begin
        r_err <= w_err_next;
        if (w_mismatch && !r_seen) begin
          r_first <= r_vec;
          r_seen  <= 1'b1;
        end
        if (r_vec != LAST_VEC) r_vec <= r_vec + VW'(1);
      end
    end
  end

  assign a_out       = r_vec[VW-1:WIDTH];
  assign b_out       = r_vec[WIDTH-1:0];
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign err_count   = r_err;
  assign first_fail  = r_first;
  assign o_dbg_state = r_state;

endmodule

// File: doc/gerador_verificador.md
GERADOR_VERIFICADOR -- requirements
Module: gerador_verificador

Interface
REQ-001 SHALL have parameter WIDTH, default 2: operand width of the comparator under test; the sweep covers 2^(2*WIDTH) vectors.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  pulse requesting a sweep.
REQ-005 SHALL have port y_in  input  1  equality result returned by the external comparator, combinational from a_out/b_out.
REQ-006 SHALL have port a_out  output  WIDTH  operand a driven to the comparator.
REQ-007 SHALL have port b_out  output  WIDTH  operand b driven to the comparator.
REQ-008 SHALL have port busy  output  1  high while in RUN.
REQ-009 SHALL have port done  output  1  high while in DONE.
REQ-010 SHALL have port pass  output  1  high in DONE when err_count==0, else 0.
REQ-011 SHALL have port err_count  output  2*WIDTH+1  number of mismatching vectors in the last or current sweep.
REQ-012 SHALL have port first_fail  output  2*WIDTH  vector {a,b} of the first mismatch; 0 if none.

Function
REQ-013 SHALL implement states IDLE, RUN and DONE, with all outputs registered.
REQ-014 SHALL go IDLE->RUN on the edge where start=1: vector index cleared to 0; err_count, first_fail and the first-fail flag cleared.
REQ-015 SHALL drive {a_out,b_out} = vector index in RUN, with a_out as the MSBs; sweep order 0,1,...,2^(2*WIDTH)-1; one vector per cycle.
REQ-016 SHALL, on each RUN edge, compare y_in with expected (a_out==b_out); on mismatch, err_count increments by 1.
REQ-017 SHALL, on the first mismatch of a sweep, load first_fail with the current vector; later mismatches SHALL NOT change it.
REQ-018 SHALL treat the edge on which the last vector is checked as the RUN->DONE transition; RUN lasts exactly 2^(2*WIDTH) cycles (16 for WIDTH=2).
REQ-019 SHALL size err_count so it never wraps; its maximum is 2^(2*WIDTH).
REQ-020 SHALL, in DONE, hold a_out/b_out at the last vector and hold err_count and first_fail.
REQ-021 SHALL make done and pass valid from the first DONE cycle onward.
REQ-022 SHALL ignore start while in RUN; it SHALL NOT restart or extend the sweep.
REQ-023 SHALL, on start in DONE, go to RUN with the same clearing as REQ-014 (restart).
REQ-024 SHALL keep pass=0 outside DONE.
REQ-025 SHALL keep a_out/b_out=0 in IDLE.

Reset
REQ-026 SHALL, with rst=1 at an edge, force state IDLE and set a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, first_fail=0.
REQ-027 SHALL give rst priority over start; a reset mid-RUN aborts the sweep with no partial result retained.
REQ-028 SHALL accept start on the first edge after rst deasserts.

Verification (WIDTH=2)
REQ-029 SHALL cover: correct equality comparator on y_in, start pulse -> busy for 16 cycles; vectors 0..15 in order; then done=1, pass=1, err_count=0, first_fail=0.
REQ-030 SHALL cover: y_in stuck at 0 -> done after 16 cycles, err_count=4, first_fail=4'b0000, pass=0.
REQ-031 SHALL cover: y_in inverted -> err_count=16 (no wrap), first_fail=4'b0000, pass=0.
REQ-032 SHALL cover: y_in forced 1 only when {a,b}=4'b0110 with otherwise correct comparator -> err_count=1, first_fail=4'b0110.
REQ-033 SHALL cover: start held high or re-pulsed at RUN cycle 5 -> sweep still ends after exactly 16 RUN cycles; rst at RUN cycle 7 -> next cycle IDLE with all outputs 0.
REQ-034 SHALL cover: start in DONE after a failing sweep, correct comparator -> err_count cleared on entry to RUN; second sweep ends pass=1.
